// File: rtl/imem_load_arbiter.sv
// Instruction-memory port arbiter: lets the CPU fetch from the single-port
// memory while running. A byte-serial loader can take over the port. It packs
// loader bytes big-endian into 32-bit words and writes them from word 0 upward.
module imem_load_arbiter #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 8,
    parameter int unsigned IW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_gnt,
    output logic [31:0]   cpu_instr,
    output logic          cpu_run,
    output logic          mem_we,
    output logic [IW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          load_done,
    output logic          load_err,
    output logic [IW:0]   words_loaded
);

    typedef enum logic [2:0] {RUN, LOAD, WRITE, DONE, ERR} state_t;

    state_t        state_q;
    logic [IW:0]   ptr_q;        // next word index; also the words-written count
    logic [1:0]    cnt_q;        // bytes already packed into word_q
    logic [31:0]   word_q;
    logic [31:0]   word_d;
    logic          last_q;       // word being written carries the final byte
    logic          cpu_run_q;
    logic          ld_ready_q;
    logic          mem_we_q;
    logic          load_done_q;
    logic          load_err_q;

    logic [AW-3:0] cpu_widx;
    logic          cpu_in_range;
    logic          start_load;
    logic          byte_acc;
    logic          ptr_at_end;
    logic          ptr_sat;
    logic          unused_addr_lsbs;

    assign cpu_widx         = cpu_addr[AW-1:2];
    assign unused_addr_lsbs = ^cpu_addr[1:0];
    assign cpu_in_range     = (32'(cpu_widx) < DEPTH);
    assign ptr_at_end       = (32'(ptr_q) == DEPTH - 1);
    assign ptr_sat          = (32'(ptr_q) >= DEPTH);

    // load_start is honoured only in RUN, LOAD and ERR. It beats a byte
    // offered in the same cycle.
    assign start_load = load_start &&
                        (state_q == RUN || state_q == LOAD || state_q == ERR);
    assign byte_acc   = (state_q == LOAD) && ld_ready_q && ld_valid && !load_start;

    // Insert the incoming byte at its big-endian lane of the word being built.
    always_comb begin
        word_d = word_q;
        case (cnt_q)
            2'd0:    word_d[31:24] = ld_byte;
            2'd1:    word_d[23:16] = ld_byte;
            2'd2:    word_d[15:8]  = ld_byte;
            default: word_d[7:0]   = ld_byte;
        endcase
    end

    // Load-control FSM. The registered outputs are updated together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ptr_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            cpu_run_q   <= 1'b1;
            ld_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else if (start_load) begin
            // A restart drops any partial word. Words already written stay in memory.
            state_q     <= LOAD;
            ptr_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            cpu_run_q   <= 1'b0;
            ld_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    cpu_run_q <= 1'b1;
                end
                LOAD: begin
                    if (byte_acc) begin
                        word_q <= word_d;
                        cnt_q  <= cnt_q + 2'd1;
                        if (ld_last || cnt_q == 2'd3) begin
                            state_q    <= WRITE;
                            last_q     <= ld_last;
                            ld_ready_q <= 1'b0;
                            mem_we_q   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    mem_we_q <= 1'b0;
                    cnt_q    <= '0;
                    word_q   <= '0;
                    if (!ptr_sat) begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                    if (last_q) begin
                        state_q     <= DONE;
                        load_done_q <= 1'b1;
                    end else if (ptr_at_end) begin
                        state_q    <= ERR;
                        load_err_q <= 1'b1;
                    end else begin
                        state_q    <= LOAD;
                        ld_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= RUN;
                    load_done_q <= 1'b0;
                    cpu_run_q   <= 1'b1;
                end
                ERR: begin
                    ld_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                end
                default: begin
                    state_q    <= RUN;
                    cpu_run_q  <= 1'b1;
                    ld_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                end
            endcase
        end
    end

    // The fetch path is combinational and is granted only while running.
    assign cpu_gnt   = (state_q == RUN) && cpu_req;
    assign cpu_instr = (cpu_gnt && cpu_in_range) ? mem_rdata : '0;
    assign mem_addr  = (state_q == WRITE) ? ptr_q[IW-1:0] : IW'(cpu_widx);
    assign mem_wdata = word_q;

    assign mem_we       = mem_we_q;
    assign ld_ready     = ld_ready_q;
    assign cpu_run      = cpu_run_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = ptr_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter. It models the instruction memory and records
// every write the block performs.
module tb_imem_load_arbiter;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 8;
    localparam int unsigned IW    = 6;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_last;
    logic          ld_ready;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic [31:0]   cpu_instr;
    logic          cpu_run;
    logic          mem_we;
    logic [IW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          load_done;
    logic          load_err;
    logic [IW:0]   words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]   tbmem   [DEPTH];
    logic [31:0]   pattern [DEPTH];
    logic          use_pat;
    logic          prev_we;
    logic [IW-1:0] wr_addr [$];
    logic [31:0]   wr_data [$];
    logic [7:0]    prog    [$];
    logic [31:0]   exp_w   [$];

    imem_load_arbiter #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_instr(cpu_instr), .cpu_run(cpu_run),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = use_pat ? pattern[mem_addr] : tbmem[mem_addr];

    // Memory array plus a write recorder. Two writes in back-to-back cycles are an error.
    always @(posedge clk) begin
        if (mem_we) begin
            tbmem[mem_addr] <= mem_wdata;
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            n_tests++;
            if (prev_we === 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back_write addr=%0d (consecutive mem_we required=0)", mem_addr);
            end
        end
        prev_we <= rst ? 1'b0 : mem_we;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: bytes are packed four per word, big-endian, with zero fill.
    // At most DEPTH words are written.
    task automatic model_program();
        exp_w.delete();
        for (int i = 0; i < prog.size(); i++) begin
            if (i % 4 == 0) exp_w.push_back(32'h0);
            exp_w[i/4] = exp_w[i/4] | (32'(prog[i]) << (24 - 8 * (i % 4)));
        end
        while (exp_w.size() > DEPTH) void'(exp_w.pop_back());
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
        cpu_req = 1'b0; cpu_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_load_start();
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk) load_start = 1'b1;
        @(negedge clk) load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ld_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        @(posedge clk);
        #1 ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic send_prog(input bit with_last, input int gap_max);
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < prog.size(); i++) begin
            repeat (int'($urandom_range(gap_max, 0))) @(negedge clk);
            send_byte(prog[i], with_last && (i == prog.size() - 1), ok);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
        end
        n_tests++;
        if (!all_ok) begin
            n_fail++;
            $display("FAIL send_prog: ld_ready stayed 0 (required 1 within 50 cycles)");
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (load_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        n_tests++;
        if ({cpu_run, ld_ready, mem_we, load_done, load_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags got run/rdy/we/done/err=%b required=10000",
                     {cpu_run, ld_ready, mem_we, load_done, load_err});
        end
        n_tests++;
        if (words_loaded !== '0) begin
            n_fail++;
            $display("FAIL reset_words got=%0d required=0", words_loaded);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_i;
        use_pat = 1'b1;
        for (int i = 0; i < DEPTH; i++) pattern[i] = $urandom;
        pattern[1] = 32'hac250004;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cpu_req  = (i == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            cpu_addr = (i == 0) ? 8'h04 : 8'($urandom);
            #1;
            exp_i = cpu_req ? pattern[cpu_addr / 4] : 32'h0;
            n_tests++;
            if (cpu_gnt !== cpu_req || cpu_run !== 1'b1) begin
                n_fail++;
                $display("FAIL fetch_gnt addr=%h got gnt=%b run=%b required gnt=%b run=1",
                         cpu_addr, cpu_gnt, cpu_run, cpu_req);
            end
            n_tests++;
            if (mem_addr !== IW'(cpu_addr / 4) || cpu_instr !== exp_i) begin
                n_fail++;
                $display("FAIL fetch_data addr=%h got idx=%0d instr=%h required idx=%0d instr=%h",
                         cpu_addr, mem_addr, cpu_instr, cpu_addr / 4, exp_i);
            end
        end
        use_pat = 1'b0;
    endtask

    task automatic test_load_directed();
        bit ok;
        logic [7:0] p1 [8];
        p1 = '{8'h00, 8'h24, 8'h28, 8'h20, 8'hac, 8'h25, 8'h00, 8'h04};
        prog.delete();
        foreach (p1[i]) prog.push_back(p1[i]);
        model_program();
        pulse_load_start();
        cpu_req = 1'b1; cpu_addr = 8'h04;
        #1;
        n_tests++;
        if (cpu_gnt !== 1'b0 || cpu_instr !== 32'h0 || cpu_run !== 1'b0 || ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_load_block got gnt=%b instr=%h run=%b rdy=%b required 0,0,0,1",
                     cpu_gnt, cpu_instr, cpu_run, ld_ready);
        end
        send_prog(1'b1, 0);
        wait_done(ok);
        n_tests++;
        if (!ok || cpu_run !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_done got done_seen=%b run=%b required 1,0", ok, cpu_run);
        end
        @(negedge clk);
        n_tests++;
        if (cpu_run !== 1'b1 || load_done !== 1'b0 || words_loaded !== 7'd2) begin
            n_fail++;
            $display("FAIL dir_after got run=%b done=%b words=%0d required 1,0,2",
                     cpu_run, load_done, words_loaded);
        end
        n_tests++;
        if (wr_addr.size() !== exp_w.size()) begin
            n_fail++;
            $display("FAIL dir_wr_count got=%0d required=%0d", wr_addr.size(), exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && k < wr_addr.size(); k++) begin
            n_tests++;
            if (wr_addr[k] !== IW'(k) || wr_data[k] !== exp_w[k]) begin
                n_fail++;
                $display("FAIL dir_write[%0d] got (%0d,%h) required (%0d,%h)",
                         k, wr_addr[k], wr_data[k], k, exp_w[k]);
            end
        end
        #1;
        n_tests++;
        if (cpu_gnt !== 1'b1 || cpu_instr !== 32'hac250004) begin
            n_fail++;
            $display("FAIL readback got gnt=%b instr=%h required 1,ac250004", cpu_gnt, cpu_instr);
        end
        // A short program whose last byte ends a partial word.
        prog.delete();
        prog.push_back(8'h8c); prog.push_back(8'h26); prog.push_back(8'h00);
        model_program();
        pulse_load_start();
        send_prog(1'b1, 0);
        wait_done(ok);
        n_tests++;
        if (!ok || wr_addr.size() !== 1 || wr_addr[0] !== '0 || wr_data[0] !== 32'h8c260000) begin
            n_fail++;
            $display("FAIL short_prog got done_seen=%b writes=%0d required 1 write (0,8c260000)",
                     ok, wr_addr.size());
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_load_random();
        bit ok;
        for (int it = 0; it < 4; it++) begin
            prog.delete();
            repeat (int'($urandom_range(48, 1))) prog.push_back(8'($urandom));
            model_program();
            pulse_load_start();
            cpu_req = 1'b1; cpu_addr = 8'($urandom);
            send_prog(1'b1, 3);
            wait_done(ok);
            @(negedge clk);
            n_tests++;
            if (!ok || words_loaded !== 7'(exp_w.size()) || cpu_run !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_done got done_seen=%b words=%0d run=%b required 1,%0d,1",
                         it, ok, words_loaded, cpu_run, exp_w.size());
            end
            n_tests++;
            if (wr_addr.size() !== exp_w.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_wr_count got=%0d required=%0d", it, wr_addr.size(), exp_w.size());
            end
            for (int k = 0; k < exp_w.size() && k < wr_addr.size(); k++) begin
                n_tests++;
                if (wr_addr[k] !== IW'(k) || wr_data[k] !== exp_w[k]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_write[%0d] got (%0d,%h) required (%0d,%h)",
                             it, k, wr_addr[k], wr_data[k], k, exp_w[k]);
                end
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_overflow();
        bit ok;
        prog.delete();
        repeat (DEPTH * 4) prog.push_back(8'($urandom));
        model_program();
        pulse_load_start();
        send_prog(1'b0, 0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (load_err !== 1'b1 || ld_ready !== 1'b0 || cpu_run !== 1'b0 || words_loaded !== 7'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovf_state got err=%b rdy=%b run=%b words=%0d required 1,0,0,%0d",
                     load_err, ld_ready, cpu_run, words_loaded, DEPTH);
        end
        // A byte offered in the error state must be ignored.
        ld_valid = 1'b1; ld_byte = 8'h5a;
        repeat (3) @(negedge clk);
        ld_valid = 1'b0;
        n_tests++;
        if (wr_addr.size() !== exp_w.size() || load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_count got writes=%0d err=%b required %0d,1", wr_addr.size(), load_err, exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && k < wr_addr.size(); k++) begin
            n_tests++;
            if (wr_addr[k] !== IW'(k) || wr_data[k] !== exp_w[k]) begin
                n_fail++;
                $display("FAIL ovf_write[%0d] got (%0d,%h) required (%0d,%h)",
                         k, wr_addr[k], wr_data[k], k, exp_w[k]);
            end
        end
        pulse_load_start();
        n_tests++;
        if (load_err !== 1'b0 || ld_ready !== 1'b1 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL ovf_restart got err=%b rdy=%b words=%0d required 0,1,0", load_err, ld_ready, words_loaded);
        end
        prog.delete();
        prog.push_back(8'h13); prog.push_back(8'h00); prog.push_back(8'h00); prog.push_back(8'h93);
        send_prog(1'b1, 1);
        wait_done(ok);
        n_tests++;
        if (!ok || wr_addr.size() !== 1 || wr_addr[0] !== '0 || wr_data[0] !== 32'h13000093) begin
            n_fail++;
            $display("FAIL ovf_reload got done_seen=%b writes=%0d required 1 write (0,13000093)", ok, wr_addr.size());
        end
    endtask

    task automatic test_restart();
        bit ok;
        pulse_load_start();
        prog.delete();
        prog.push_back(8'haa); prog.push_back(8'hbb);
        send_prog(1'b0, 0);
        // Restart collides with a valid byte; the byte must be dropped.
        @(negedge clk);
        load_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hcc;
        @(negedge clk);
        load_start = 1'b0; ld_valid = 1'b0;
        prog.delete();
        prog.push_back(8'h11); prog.push_back(8'h22); prog.push_back(8'h33); prog.push_back(8'h44);
        send_prog(1'b1, 2);
        wait_done(ok);
        @(negedge clk);
        n_tests++;
        if (!ok || wr_addr.size() !== 1 || words_loaded !== 7'd1) begin
            n_fail++;
            $display("FAIL restart_count got done_seen=%b writes=%0d words=%0d required 1,1,1",
                     ok, wr_addr.size(), words_loaded);
        end
        n_tests++;
        if (wr_addr.size() > 0 && (wr_addr[0] !== '0 || wr_data[0] !== 32'h11223344)) begin
            n_fail++;
            $display("FAIL restart_write got (%0d,%h) required (0,11223344)", wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_reset_midload();
        pulse_load_start();
        prog.delete();
        repeat (5) prog.push_back(8'($urandom));
        model_program();
        send_prog(1'b0, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        n_tests++;
        if (cpu_run !== 1'b1 || load_err !== 1'b0 || ld_ready !== 1'b0 || words_loaded !== '0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state got run=%b err=%b rdy=%b words=%0d we=%b required 1,0,0,0,0",
                     cpu_run, load_err, ld_ready, words_loaded, mem_we);
        end
        ld_valid = 1'b1; ld_byte = 8'h77;
        repeat (10) @(negedge clk);
        ld_valid = 1'b0;
        n_tests++;
        if (wr_addr.size() !== 1 || wr_data[0] !== exp_w[0]) begin
            n_fail++;
            $display("FAIL midrst_writes got=%0d required=1 (word %h)", wr_addr.size(), exp_w[0]);
        end
    endtask

    initial begin
        use_pat = 1'b0;
        test_reset();
        test_fetch();
        test_load_directed();
        test_load_random();
        test_overflow();
        test_restart();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Controls and arbitrates a single-port instruction memory (combinational read, synchronous write) between two requesters: the CPU fetch path and a byte-serial program loader.
- Assembles loader bytes into 32-bit words, writes them sequentially from word 0, and holds the CPU off the memory while a load is in progress.
- Sits between the single-cycle core's PC/fetch logic and the instruction memory array.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in the memory.
- AW, 8, width of the CPU byte address; word index = addr[AW-1:2].
- IW, 6, width of the memory word index; must satisfy 2**IW >= DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse; begins a program load at word 0.
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader data byte.
- ld_last  in  1  qualifies ld_byte as the final byte of the program.
- ld_ready  out  1  block accepts a byte this cycle.
- cpu_req  in  1  CPU fetch request.
- cpu_addr  in  AW  CPU fetch byte address.
- cpu_gnt  out  1  fetch granted this cycle.
- cpu_instr  out  32  fetched instruction.
- cpu_run  out  1  CPU enable; 0 freezes the PC.
- mem_we  out  1  memory write enable.
- mem_addr  out  IW  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data (combinational from mem_addr).
- load_done  out  1  one-cycle pulse when a load completes.
- load_err  out  1  sticky overflow flag.
- words_loaded  out  IW+1  count of words written by the current or last load.

Behaviour:
- FSM states: RUN, LOAD, WRITE, DONE, ERR.
- Reset:
  - state=RUN, cpu_run=1, ld_ready=0, mem_we=0, load_done=0, load_err=0, words_loaded=0.
  - Internal byte count and assembly register cleared.
  - Reset overrides every other input in every state, including mid-load.
- RUN:
  - cpu_gnt=cpu_req; mem_addr=cpu_addr[AW-1:2].
  - cpu_instr=mem_rdata when granted and word index < DEPTH; otherwise 32'h00000000 (nop).
  - Read path is purely combinational, zero-cycle latency.
- RUN + load_start:
  - Next cycle enters LOAD with cpu_run=0, word pointer=0, byte count=0, words_loaded=0, load_err=0.
- LOAD:
  - ld_ready=1, cpu_gnt=0, cpu_instr=0.
  - A byte is accepted when ld_valid && ld_ready.
  - Packing is big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
  - After the 4th accepted byte, or any byte with ld_last=1, the next state is WRITE.
  - On ld_last before the 4th byte, the unfilled low bytes are zero.
- WRITE (exactly one cycle):
  - ld_ready=0, mem_we=1, mem_addr=word pointer, mem_wdata=assembled word.
  - Word pointer and words_loaded increment; byte count clears.
  - Next state:
    - DONE if the word carried ld_last.
    - ERR if the pointer was DEPTH-1 without ld_last.
    - LOAD otherwise.
- DONE (one cycle):
  - load_done=1, cpu_run=0.
  - Next state RUN; cpu_run=1 from then on. The CPU core handles resetting its own PC.
- ERR:
  - load_err=1 (sticky), ld_ready=0, cpu_run=0, mem_we=0.
  - Leaves only on load_start (to LOAD, clearing load_err) or rst.
- load_start handling:
  - In LOAD: restarts at word 0 and discards any partial word (already written words are not cleared).
  - In WRITE or DONE: ignored.
  - Has priority over a simultaneous ld_valid byte in LOAD; that byte is dropped.
- mem_we is asserted only in WRITE; never two writes in consecutive cycles.
- words_loaded saturates at DEPTH.

Test Plan:
- rst, then cpu_req=1, cpu_addr=8'h04, mem_rdata=32'hac250004 -> cpu_gnt=1, mem_addr=1, cpu_instr=32'hac250004, cpu_run=1.
- load_start; bytes 00,24,28,20,ac,25,00,04 (last on 04), one per cycle -> mem_we pulses with (0, 32'h00242820) and (1, 32'hac250004); load_done one cycle later; cpu_run=1 the cycle after; words_loaded=2.
- load_start; bytes 8c,26,00 with ld_last on 00 -> single write (0, 32'h8c260000); load_done=1.
- During LOAD, cpu_req=1 -> cpu_gnt=0, cpu_instr=0, cpu_run=0. ld_valid gaps stall assembly with no spurious writes.
- Load 65 full words without ld_last -> 64 writes (addr 0..63), then ERR: load_err=1, ld_ready=0. A subsequent load_start clears load_err and restarts at word 0.
- Mid-load: after 2 bytes, assert load_start -> partial word discarded, next write at addr 0. After 5 bytes, assert rst -> RUN, cpu_run=1, load_err=0, no further writes.
